// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one memory read per fetch request, holds the
// returned word until decode accepts it, and traps misaligned or timed-out fetches.
module instr_fetch #(
  parameter int PC_BITS    = 6,
  parameter int INSTR_BITS = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clka,
  input  logic                  reset,
  input  logic                  fetch_start,
  input  logic [PC_BITS-1:0]    pc,
  input  logic                  flush,
  input  logic [INSTR_BITS-1:0] mem_rdata,
  input  logic                  mem_ack,
  input  logic                  dec_ready,
  output logic                  mem_req,
  output logic [PC_BITS-1:0]    mem_addr,
  output logic [INSTR_BITS-1:0] instr,
  output logic [PC_BITS-1:0]    instr_pc,
  output logic                  instr_valid,
  output logic                  pc_advance,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [7:0]            fetch_count
);

  localparam int WAIT_BITS = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(TIMEOUT - 1);
  localparam logic [1:0] CODE_NONE      = 2'b00;
  localparam logic [1:0] CODE_MISALIGN  = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT   = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

  state_t               state_reg;
  logic [WAIT_BITS-1:0] wait_reg;
  logic                 handshake;
  logic                 can_launch;

  // A new fetch may start from IDLE, or back-to-back in the cycle decode takes the held word.
  always_comb begin
    handshake  = (state_reg == HOLD) && dec_ready;
    can_launch = (state_reg == IDLE) || handshake;
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      state_reg   <= IDLE;
      wait_reg    <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      pc_advance  <= 1'b0;
      err         <= 1'b0;
      err_code    <= CODE_NONE;
      fetch_count <= 8'd0;
    end else if (flush) begin
      state_reg   <= IDLE;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      pc_advance  <= 1'b0;
      err         <= 1'b0;
      err_code    <= CODE_NONE;
    end else begin
      pc_advance <= 1'b0;
      unique case (state_reg)
        IDLE: ;
        REQ: begin
          // An ack in the last allowed cycle takes priority over the timeout.
          if (mem_ack) begin
            instr       <= mem_rdata;
            instr_pc    <= mem_addr;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            state_reg   <= HOLD;
          end else if (wait_reg == WAIT_LAST) begin
            mem_req   <= 1'b0;
            err       <= 1'b1;
            err_code  <= CODE_TIMEOUT;
            state_reg <= ERR;
          end else begin
            wait_reg <= wait_reg + WAIT_BITS'(1);
          end
        end
        HOLD: begin
          if (dec_ready) begin
            fetch_count <= fetch_count + 8'd1;
            pc_advance  <= 1'b1;
            instr_valid <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        ERR: ;
      endcase

      if (can_launch && fetch_start) begin
        if (pc[0]) begin
          err       <= 1'b1;
          err_code  <= CODE_MISALIGN;
          state_reg <= ERR;
        end else begin
          mem_addr  <= pc;
          mem_req   <= 1'b1;
          wait_reg  <= '0;
          state_reg <= REQ;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model.
module tb_instr_fetch;
  localparam int PC_BITS    = 6;
  localparam int INSTR_BITS = 16;
  localparam int TIMEOUT    = 15;

  logic                  clka = 1'b0;
  logic                  reset = 1'b1;
  logic                  fetch_start = 1'b0;
  logic [PC_BITS-1:0]    pc = '0;
  logic                  flush = 1'b0;
  logic [INSTR_BITS-1:0] mem_rdata = '0;
  logic                  mem_ack = 1'b0;
  logic                  dec_ready = 1'b0;
  logic                  mem_req;
  logic [PC_BITS-1:0]    mem_addr;
  logic [INSTR_BITS-1:0] instr;
  logic [PC_BITS-1:0]    instr_pc;
  logic                  instr_valid;
  logic                  pc_advance;
  logic                  err;
  logic [1:0]            err_code;
  logic [7:0]            fetch_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_fetches = 0;

  always #5 clka = ~clka;

  instr_fetch #(.PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clka(clka), .reset(reset), .fetch_start(fetch_start), .pc(pc), .flush(flush),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dec_ready(dec_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .pc_advance(pc_advance), .err(err),
    .err_code(err_code), .fetch_count(fetch_count)
  );

  // Reference model: what the stage is doing, not how it encodes it.
  bit                    m_busy, m_have, m_fault, m_adv;
  int                    m_left;
  logic [1:0]            m_code;
  logic [PC_BITS-1:0]    m_addr, m_ipc;
  logic [INSTR_BITS-1:0] m_instr;
  logic [7:0]            m_count;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_launch();
    if (fetch_start) begin
      if (pc[0]) begin
        m_fault = 1'b1;
        m_code  = 2'b01;
      end else begin
        m_busy = 1'b1;
        m_addr = pc;
        m_left = TIMEOUT;
      end
    end
  endtask

  task automatic model_step();
    m_adv = 1'b0;
    if (reset) begin
      m_busy = 0; m_have = 0; m_fault = 0; m_left = 0; m_code = 2'b00;
      m_addr = '0; m_ipc = '0; m_instr = '0; m_count = 8'd0;
    end else if (flush) begin
      m_busy = 0; m_have = 0; m_fault = 0; m_code = 2'b00;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_instr = mem_rdata;
        m_ipc   = m_addr;
        m_busy  = 1'b0;
        m_have  = 1'b1;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy  = 1'b0;
          m_fault = 1'b1;
          m_code  = 2'b10;
        end
      end
    end else if (m_have) begin
      if (dec_ready) begin
        m_count++;
        m_adv  = 1'b1;
        m_have = 1'b0;
        n_fetches++;
        $display("fetch %0d: pc=0x%02h instr=0x%04h count=%0d", n_fetches, m_ipc, m_instr, m_count);
        model_launch();
      end
    end else if (!m_fault) begin
      model_launch();
    end
  endtask

  task automatic compare_all();
    check_eq("mem_req",     32'(mem_req),     32'(m_busy));
    check_eq("mem_addr",    32'(mem_addr),    32'(m_addr));
    check_eq("instr",       32'(instr),       32'(m_instr));
    check_eq("instr_pc",    32'(instr_pc),    32'(m_ipc));
    check_eq("instr_valid", 32'(instr_valid), 32'(m_have));
    check_eq("pc_advance",  32'(pc_advance),  32'(m_adv));
    check_eq("err",         32'(err),         32'(m_fault));
    check_eq("err_code",    32'(err_code),    32'(m_code));
    check_eq("fetch_count", 32'(fetch_count), 32'(m_count));
  endtask

  task automatic tick(input bit fs, input logic [PC_BITS-1:0] p, input bit fl, input bit ack,
                      input logic [INSTR_BITS-1:0] rd, input bit dr, input bit rst);
    fetch_start = fs; pc = p; flush = fl; mem_ack = ack;
    mem_rdata = rd; dec_ready = dr; reset = rst;
    @(posedge clka);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_tick();
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  logic [7:0] cnt_before;

  initial begin
    // Reset state
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_count", 32'(fetch_count), 32'd0);
    idle_tick();

    // Basic fetch: start in cycle 0, ack in cycle 2, decode ready
    tick(1'b1, 6'h04, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("c1_mem_req", 32'(mem_req), 32'd1);
    check_eq("c1_mem_addr", 32'(mem_addr), 32'h04);
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("c2_mem_req", 32'(mem_req), 32'd1);
    tick(1'b0, '0, 1'b0, 1'b1, 16'hA5C3, 1'b1, 1'b0);
    check_eq("c3_valid", 32'(instr_valid), 32'd1);
    check_eq("c3_instr", 32'(instr), 32'hA5C3);
    check_eq("c3_instr_pc", 32'(instr_pc), 32'h04);
    check_eq("c3_mem_req", 32'(mem_req), 32'd0);
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("c4_pc_advance", 32'(pc_advance), 32'd1);
    check_eq("c4_count", 32'(fetch_count), 32'd1);
    idle_tick();
    check_eq("c5_pc_advance", 32'(pc_advance), 32'd0);

    // Misaligned fetch, then flush
    tick(1'b1, 6'h05, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("mis_err", 32'(err), 32'd1);
    check_eq("mis_code", 32'(err_code), 32'd1);
    check_eq("mis_mem_req", 32'(mem_req), 32'd0);
    tick(1'b1, 6'h08, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("mis_sticky_req", 32'(mem_req), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_eq("mis_flush_err", 32'(err), 32'd0);
    check_eq("mis_flush_code", 32'(err_code), 32'd0);

    // Timeout: 15 REQ cycles without ack
    tick(1'b1, 6'h08, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) idle_tick();
    check_eq("to_still_req", 32'(mem_req), 32'd1);
    idle_tick();
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_code", 32'(err_code), 32'd2);
    check_eq("to_mem_req", 32'(mem_req), 32'd0);
    tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Ack on the 15th REQ cycle wins
    tick(1'b1, 6'h08, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) idle_tick();
    tick(1'b0, '0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    check_eq("late_ack_valid", 32'(instr_valid), 32'd1);
    check_eq("late_ack_err", 32'(err), 32'd0);
    check_eq("late_ack_instr", 32'(instr), 32'h1234);
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Decode stall for 5 cycles, then back-to-back fetch at 0x06
    tick(1'b1, 6'h02, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 6'h0C, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
      check_eq("stall_instr", 32'(instr), 32'hBEEF);
      check_eq("stall_pc", 32'(instr_pc), 32'h02);
    end
    tick(1'b1, 6'h06, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("b2b_mem_req", 32'(mem_req), 32'd1);
    check_eq("b2b_mem_addr", 32'(mem_addr), 32'h06);
    check_eq("b2b_advance", 32'(pc_advance), 32'd1);
    tick(1'b0, '0, 1'b0, 1'b1, 16'h0F0F, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Flush coinciding with ack
    tick(1'b1, 6'h0A, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cnt_before = m_count;
    tick(1'b0, '0, 1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b0);
    check_eq("fl_ack_valid", 32'(instr_valid), 32'd0);
    check_eq("fl_ack_req", 32'(mem_req), 32'd0);
    check_eq("fl_ack_count", 32'(fetch_count), 32'(cnt_before));
    // Flush coinciding with handshake
    tick(1'b1, 6'h0A, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1, 16'hCAFE, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    idle_tick();
    check_eq("fl_hs_advance", 32'(pc_advance), 32'd0);
    check_eq("fl_hs_count", 32'(fetch_count), 32'(cnt_before));
    // Reset in REQ
    tick(1'b1, 6'h10, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(1'b1, 6'h12, 1'b1, 1'b1, 16'h7777, 1'b1, 1'b1);
    check_eq("rst_req_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_req_req", 32'(mem_req), 32'd0);
    check_eq("rst_req_count", 32'(fetch_count), 32'd0);
    idle_tick();

    // 256 completed fetches wrap the counter
    for (int i = 0; i < 256; i++) begin
      tick(1'b1, 6'($urandom) & 6'h3E, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b1, 16'($urandom), 1'b0, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      if (i == 254) check_eq("wrap_255", 32'(fetch_count), 32'd255);
    end
    check_eq("wrap_0", 32'(fetch_count), 32'd0);

    // Randomized traffic with varying memory responsiveness
    for (int blk = 0; blk < 6; blk++) begin
      int ack_pct;
      ack_pct = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 40 : 90);
      for (int i = 0; i < 500; i++) begin
        tick($urandom_range(99) < 50, 6'($urandom), $urandom_range(99) < 4,
             $urandom_range(99) < ack_pct, 16'($urandom), $urandom_range(99) < 50,
             $urandom_range(299) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
